ov_sccb_responder: RTL and testbench
====================================

Name: ov_sccb_responder

Overview:
- SCCB target (slave) that answers the 3-phase write and 2-phase write/read transactions issued by our camera-init SCCB master.
- Contains a 256x8 register file that emulates the OV7670 control-register space.
- Used in simulation benches and on the FPGA to loop back the init sequencer without a camera.
- Reports every completed write on a one-cycle strobe so checkers and downstream models can track register state.

Parameters:
- CHIP_ADDR, 8'h42, 7-bit device ID in bits [7:1]; bit 0 is ignored for matching.
- FILT_LEN, 3, number of consecutive equal synchronized samples required before a line level change is accepted.

Ports:
- clk  in  1  system clock; must be >= 16x the sio_c frequency.
- reset  in  1  synchronous, active-low reset.
- sio_c  in  1  SCCB clock from the master; asynchronous.
- sio_d_i  in  1  SCCB data line as sampled from the pad; asynchronous.
- sio_d_oe  out  1  1 = pull sio_d low (open-drain); 0 = release the line.
- wr_valid  out  1  one-cycle strobe when a data byte is committed to the register file.
- wr_addr  out  8  subaddress of the committed byte.
- wr_data  out  8  value of the committed byte.
- busy  out  1  high from START until STOP.

Behaviour:
- Reset (reset==0 at posedge clk):
  - state=S_IDLE; sio_d_oe=0; wr_valid=0; wr_addr=0; wr_data=0; busy=0.
  - Subaddress pointer=0; all register-file bytes=8'h00.
- Input conditioning:
  - 2-flop synchronizer on sio_c and sio_d_i.
  - Filter: a line's level changes only after FILT_LEN equal samples.
  - Edge detect on the filtered lines.
- Bus conditions:
  - START = filtered sio_d falls while filtered sio_c is high.
  - STOP = filtered sio_d rises while filtered sio_c is high.
  - Input bits are sampled on the rising edge of filtered sio_c, MSB first.
  - sio_d_oe changes only on the falling edge of filtered sio_c.
- States: S_IDLE, S_ID, S_ID_ACK, S_SUB, S_SUB_ACK, S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_NA, S_IGNORE.
- Transitions:
  - S_IDLE: START -> S_ID, busy=1.
  - S_ID: after 8 bits, compare id[7:1] with CHIP_ADDR[7:1]. Match -> S_ID_ACK. Mismatch -> S_IGNORE (no ACK).
  - S_ID_ACK:
    - On the falling edge after bit 8, sio_d_oe=1; release it on the next falling edge.
    - Then id[0]==0 -> S_SUB; id[0]==1 -> S_RDATA, loading byte regfile[ptr] into the shifter.
  - S_SUB: after 8 bits, ptr=byte -> S_SUB_ACK (ACK as above) -> S_WDATA.
  - S_WDATA:
    - After 8 bits, write regfile[ptr]=byte.
    - In the same clk cycle: wr_valid=1, wr_addr=ptr, wr_data=byte.
    - -> S_WDATA_ACK (ACK as above) -> S_WDATA. Further bytes overwrite regfile[ptr] unless the feature below is enabled.
  - S_RDATA:
    - Drive the shifter MSB first: sio_d_oe = ~bit, updated on each falling edge.
    - After 8 bits, release the line -> S_RDATA_NA.
    - S_RDATA_NA samples the master's NA bit: NA=1 -> S_IGNORE; NA=0 -> reload regfile[ptr] and return to S_RDATA.
  - S_IGNORE: holds sio_d_oe=0 and waits.
- Overrides in every state:
  - STOP -> S_IDLE, sio_d_oe=0, busy=0.
  - START (repeated) -> S_ID with the bit counter cleared; ptr is retained, which provides the 2-phase write then 2-phase read.
- Partial byte before STOP: discarded; no regfile write and no wr_valid.
- reset asserted mid-transaction: line is released immediately and the block returns to the reset values above.
- ptr arithmetic is 8-bit and wraps 8'hFF -> 8'h00.

Optional Feature:
- Macro: OV_SCCB_RESP_AUTOINC_EN.
- Defined: ptr increments (mod 256) after each committed write byte and after each read byte.
- Undefined: ptr stays fixed for the whole transaction; repeated bytes target the same address.

Decomposition:
- Package ov_sccb_pkg holds:
  - state enum/localparams;
  - SCCB_BITS=8;
  - ACK level constant;
  - default CHIP_ADDR 8'h42 and read ID 8'h43.
- Sub-module ov_sccb_line_filter: one instance per line; contains synchronizer, FILT_LEN filter, rise/fall strobes.

Test Plan:
- Write: START, 8'h42, 8'h12, 8'h04, STOP -> ACK low on all three 9th bits; wr_valid exactly once with wr_addr=8'h12, wr_data=8'h04; busy falls after STOP.
- Read-back: after the write above, START, 8'h42, 8'h12, STOP, START, 8'h43, read, NA=1, STOP -> returned byte 8'h04; sio_d_oe=0 after NA.
- Wrong ID: START, 8'h60, 8'h12, 8'h55, STOP -> no ACK; sio_d_oe stays 0; no wr_valid; regfile[8'h12] unchanged.
- Mid-transaction abort:
  - STOP after 4 bits of the data byte -> no wr_valid.
  - reset pulsed during the S_RDATA driving phase -> sio_d_oe=0 the next cycle; regfile cleared.
- Glitch: 1-clk pulse on sio_c during a data byte -> filtered out; the byte is still received correctly (8'hA5 at 8'h3A).
- Feature on: write 8'h11, 8'h22 starting at sub 8'hFF -> commits at 8'hFF then 8'h00. Feature off -> both commit at 8'hFF; final value 8'h22.

Source files
------------

// File: rtl/ov_sccb_pkg.sv
// ov_sccb_pkg: FSM states and SCCB constants shared by the responder files
package ov_sccb_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_ID, S_ID_ACK, S_SUB, S_SUB_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_NA, S_IGNORE
  } sccb_state_t;
  localparam int SCCB_BITS = 8;
  localparam logic ACK_LVL = 1'b0;
  localparam logic [7:0] DEF_CHIP_ADDR = 8'h42;
  localparam logic [7:0] DEF_READ_ID = 8'h43;
endpackage

// File: rtl/ov_sccb_responder_if.sv
// ov_sccb_responder_if: SCCB pad signals plus the register-write report port
interface ov_sccb_responder_if;
  logic sio_c, sio_d_i, sio_d_oe, wr_valid, busy;
  logic [7:0] wr_addr, wr_data;
  modport master (output sio_c, sio_d_i, input sio_d_oe, wr_valid, wr_addr, wr_data, busy);
  modport slave (input sio_c, sio_d_i, output sio_d_oe, wr_valid, wr_addr, wr_data, busy);
endinterface

// File: rtl/ov_sccb_line_filter.sv
// ov_sccb_line_filter: 2-flop synchronizer, FILT_LEN-sample level filter and edge strobes
module ov_sccb_line_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);
  logic [1:0] sync;
  logic [FILT_LEN-1:0] hist;
  logic nxt;
  assign nxt = &hist ? 1'b1 : ~|hist ? 1'b0 : lvl;
  always_ff @(posedge clk)
    if (!reset) begin
      sync <= 2'b11;
      hist <= '1;
      lvl <= 1'b1;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[0], din};
      hist <= (hist << 1) | FILT_LEN'(sync[1]);
      lvl <= nxt;
      rise <= nxt & ~lvl;
      fall <= ~nxt & lvl;
    end
endmodule

// File: rtl/ov_sccb_responder.sv
// ov_sccb_responder: SCCB target with 256x8 register file; OV_SCCB_RESP_AUTOINC_EN enables pointer auto-increment
module ov_sccb_responder
  import ov_sccb_pkg::*;
#(
  parameter logic [7:0] CHIP_ADDR = DEF_CHIP_ADDR,
  parameter int FILT_LEN = 3
) (
  input logic clk,
  input logic reset,
  ov_sccb_responder_if.slave bus
);
  logic scl, scl_r, scl_f, sda, sda_r, sda_f;
  ov_sccb_line_filter #(.FILT_LEN(FILT_LEN)) u_scl (
    .clk(clk), .reset(reset), .din(bus.sio_c), .lvl(scl), .rise(scl_r), .fall(scl_f)
  );
  ov_sccb_line_filter #(.FILT_LEN(FILT_LEN)) u_sda (
    .clk(clk), .reset(reset), .din(bus.sio_d_i), .lvl(sda), .rise(sda_r), .fall(sda_f)
  );
  sccb_state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [7:0] sh, sh_n, ptr, ptr_n, rx, rd, wr_addr, wr_data;
  logic [7:0] mem [256];
  logic oe, oe_n, busy, busy_n, we, wr_valid, start, stop;
  assign start = sda_f & scl;
  assign stop = sda_r & scl;
  assign rx = {sh[6:0], sda};
  assign rd = mem[ptr];
  assign bus.sio_d_oe = oe;
  assign bus.busy = busy;
  assign bus.wr_valid = wr_valid;
  assign bus.wr_addr = wr_addr;
  assign bus.wr_data = wr_data;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sh_n = sh;
    ptr_n = ptr;
    oe_n = oe;
    busy_n = busy;
    we = 1'b0;
    if (start) begin
      state_n = S_ID;
      cnt_n = '0;
      oe_n = 1'b0;
      busy_n = 1'b1;
    end else if (stop) begin
      state_n = S_IDLE;
      cnt_n = '0;
      oe_n = 1'b0;
      busy_n = 1'b0;
    end else begin
      case (state)
        S_ID, S_SUB, S_WDATA: if (scl_r) begin
          sh_n = rx;
          cnt_n = cnt + 4'd1;
          if (cnt == 4'(SCCB_BITS - 1)) begin
            cnt_n = '0;
            state_n = state == S_ID ? (rx[7:1] == CHIP_ADDR[7:1] ? S_ID_ACK : S_IGNORE)
                    : state == S_SUB ? S_SUB_ACK : S_WDATA_ACK;
            if (state == S_SUB) ptr_n = rx;
            if (state == S_WDATA) begin
              we = 1'b1;
`ifdef OV_SCCB_RESP_AUTOINC_EN
              ptr_n = ptr + 8'd1;
`endif
            end
          end
        end
        // first fall after the byte asserts ACK, the next one releases it
        S_ID_ACK, S_SUB_ACK, S_WDATA_ACK: if (scl_f) begin
          oe_n = oe ? 1'b0 : ~ACK_LVL;
          if (oe) state_n = state != S_ID_ACK ? S_WDATA : sh[0] ? S_RDATA : S_SUB;
          if (oe && state == S_ID_ACK && sh[0]) begin
            sh_n = rd;
            oe_n = ~rd[7];
          end
        end
        S_RDATA: if (scl_r) cnt_n = cnt + 4'd1;
        else if (scl_f) begin
          if (cnt == 4'(SCCB_BITS)) begin
            oe_n = 1'b0;
            cnt_n = '0;
            state_n = S_RDATA_NA;
`ifdef OV_SCCB_RESP_AUTOINC_EN
            ptr_n = ptr + 8'd1;
`endif
          end else begin
            oe_n = ~sh[6];
            sh_n = sh << 1;
          end
        end
        S_RDATA_NA: if (scl_r) begin
          cnt_n = 4'd1;
          sh_n[0] = sda;
        end else if (scl_f && cnt != 4'd0) begin
          cnt_n = '0;
          state_n = sh[0] ? S_IGNORE : S_RDATA;
          if (!sh[0]) begin
            sh_n = rd;
            oe_n = ~rd[7];
          end
        end
        S_IGNORE: oe_n = 1'b0;
        default: state_n = state;
      endcase
    end
  end
  always_ff @(posedge clk)
    if (!reset) begin
      state <= S_IDLE;
      cnt <= '0;
      sh <= '0;
      ptr <= '0;
      oe <= 1'b0;
      busy <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sh <= sh_n;
      ptr <= ptr_n;
      oe <= oe_n;
      busy <= busy_n;
      wr_valid <= we;
      if (we) begin
        mem[ptr] <= rx;
        wr_addr <= ptr;
        wr_data <= rx;
      end
    end
endmodule

// File: tb/tb_ov_sccb_responder.sv
// tb_ov_sccb_responder: bus-level SCCB master, register-file reference model and scoreboards
module tb_ov_sccb_responder;
  import ov_sccb_pkg::*;
  localparam int H = 16;
`ifdef OV_SCCB_RESP_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0, scl = 1'b1, sda = 1'b1, glitch = 1'b0;
  int n_checks = 0, n_err = 0, oe_hits = 0;
  logic [7:0] ref_mem [256];
  logic [7:0] ref_ptr;
  logic [7:0] wq [$];
  logic [15:0] exp_wr [$];
  logic [7:0] exp_rd [$], got_rd [$];
  logic [15:0] mon_e;
  logic [7:0] mon_g;
  ov_sccb_responder_if bus();
  assign bus.sio_c = scl ^ glitch;
  assign bus.sio_d_i = sda & ~bus.sio_d_oe;
  ov_sccb_responder #(.CHIP_ADDR(DEF_CHIP_ADDR), .FILT_LEN(3)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // one SCL period; g injects a single-clock SCL spike while SCL is low
  task automatic bit_clk(input logic b, input bit g, output logic s);
    if (g) begin
      tick(4); glitch = 1'b1; tick(1); glitch = 1'b0; tick(3);
    end else tick(H / 2);
    sda = b; tick(H / 2);
    scl = 1'b1; tick(H / 2);
    s = bus.sio_d_i; tick(H / 2);
    scl = 1'b0;
  endtask

  task automatic do_start;
    tick(H / 2); sda = 1'b1; tick(H / 2); scl = 1'b1; tick(H / 2); sda = 1'b0; tick(H / 2); scl = 1'b0;
  endtask

  task automatic do_stop;
    tick(H / 2); sda = 1'b0; tick(H / 2); scl = 1'b1; tick(H / 2); sda = 1'b1; tick(H);
  endtask

  task automatic send(input logic [7:0] b, input int gbit, output bit acked);
    logic s;
    for (int i = 7; i >= 0; i--) bit_clk(b[i], i == gbit, s);
    bit_clk(1'b1, 1'b0, s);
    acked = !s;
  endtask

  task automatic recv(input logic na, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_clk(1'b1, 1'b0, s);
      b[i] = s;
    end
    bit_clk(na, 1'b0, s);
  endtask

  task automatic wr_txn(input logic [7:0] id, input logic [7:0] sub, input int gbyte, input int gbit);
    bit a, match;
    match = id[7:1] == DEF_CHIP_ADDR[7:1];
    do_start;
    send(id, -1, a); check("id_ack", a, match);
    check("busy_in_txn", bus.busy, 1);
    send(sub, -1, a); check("sub_ack", a, match);
    if (match) ref_ptr = sub;
    foreach (wq[i]) begin
      if (match) begin
        ref_mem[ref_ptr] = wq[i];
        exp_wr.push_back({ref_ptr, wq[i]});
      end
      send(wq[i], i == gbyte ? gbit : -1, a); check("data_ack", a, match);
      if (match && AUTOINC) ref_ptr++;
    end
    do_stop;
    check("busy_after_stop", bus.busy, 0);
  endtask

  task automatic rd_txn(input logic [7:0] sub, input int n);
    bit a;
    logic [7:0] b;
    do_start;
    send(DEF_CHIP_ADDR, -1, a); check("rd_wid_ack", a, 1);
    send(sub, -1, a); check("rd_sub_ack", a, 1);
    do_stop;
    ref_ptr = sub;
    do_start;
    send(DEF_READ_ID, -1, a); check("rd_rid_ack", a, 1);
    for (int i = 0; i < n; i++) begin
      exp_rd.push_back(ref_mem[ref_ptr]);
      if (AUTOINC) ref_ptr++;
      recv(i == n - 1, b);
      got_rd.push_back(b);
    end
    check("oe_after_na", bus.sio_d_oe, 0);
    do_stop;
  endtask

  always @(negedge clk) begin
    if (bus.sio_d_oe) oe_hits++;
    if (bus.wr_valid) begin
      if (exp_wr.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL wr_unexpected: got addr %0h data %0h expected no write", bus.wr_addr, bus.wr_data);
      end else begin
        mon_e = exp_wr.pop_front();
        check("wr_addr", bus.wr_addr, mon_e[15:8]);
        check("wr_data", bus.wr_data, mon_e[7:0]);
      end
    end
    if (got_rd.size() > 0) begin
      mon_g = got_rd.pop_front();
      if (exp_rd.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL rd_unexpected: got %0h expected nothing", mon_g);
      end else check("rd_data", mon_g, exp_rd.pop_front());
    end
  end

  initial begin
    bit a;
    int h0, n;
    logic [7:0] sub;
    logic s;
    foreach (ref_mem[i]) ref_mem[i] = 8'h00;
    ref_ptr = 8'h00;
    tick(5);
    check("rst_oe", bus.sio_d_oe, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_wr_valid", bus.wr_valid, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_wr_data", bus.wr_data, 0);
    reset = 1'b1;
    tick(20);
    wq = '{8'h04};
    wr_txn(8'h42, 8'h12, -1, -1);
    rd_txn(8'h12, 1);
    h0 = oe_hits;
    wq = '{8'h55};
    wr_txn(8'h60, 8'h12, -1, -1);
    check("wrong_id_oe", oe_hits - h0, 0);
    rd_txn(8'h12, 1);
    do_start;
    send(8'h42, -1, a); check("part_id_ack", a, 1);
    send(8'h20, -1, a); check("part_sub_ack", a, 1);
    ref_ptr = 8'h20;
    for (int i = 0; i < 4; i++) bit_clk(1'b1, 1'b0, s);
    do_stop;
    rd_txn(8'h20, 1);
    wq = '{8'hA5};
    wr_txn(8'h42, 8'h3A, 0, 3);
    rd_txn(8'h3A, 1);
    wq = '{8'h11, 8'h22};
    wr_txn(8'h42, 8'hFF, -1, -1);
    rd_txn(8'hFF, 2);
    repeat (10) begin
      sub = 8'($urandom);
      n = $urandom_range(1, 3);
      wq.delete();
      repeat (n) wq.push_back(8'($urandom));
      wr_txn(8'h42, sub, -1, -1);
      rd_txn(sub, $urandom_range(1, 3));
    end
    wq = '{8'h00};
    wr_txn(8'h42, 8'h40, -1, -1);
    do_start;
    send(8'h42, -1, a);
    send(8'h40, -1, a);
    do_stop;
    do_start;
    send(DEF_READ_ID, -1, a); check("abort_rid_ack", a, 1);
    tick(12);
    check("abort_driving", bus.sio_d_oe, 1);
    reset = 1'b0;
    tick(1);
    check("abort_oe_released", bus.sio_d_oe, 0);
    scl = 1'b1; sda = 1'b1;
    tick(3);
    reset = 1'b1;
    foreach (ref_mem[i]) ref_mem[i] = 8'h00;
    ref_ptr = 8'h00;
    tick(30);
    check("abort_busy", bus.busy, 0);
    rd_txn(8'h12, 1);
    rd_txn(8'h3A, 1);
    tick(10);
    check("wr_queue_drained", exp_wr.size(), 0);
    check("rd_queue_drained", exp_rd.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
